snake_game_ctrl: RTL and testbench

Game-level sequencer for the 8x8 snake datapath. It generates the movement tick and filters one-hot direction keys into a committed heading. It checks the next head cell against the current body before issuing each step. It runs the IDLE/RUN/PAUSE/DIE flow, including the timed restart after a self-collision. It sits between the key decoder (`po_data[3:0]`, `po_data[4]`) and the snake body register, which advances only on `step` in direction `dir`.

---
 rtl/snake_pkg.sv | 67 ++++++
 rtl/snake_game_ctrl_tick_gen.sv | 40 ++++
 rtl/snake_game_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared types and helpers for the 8x8 snake game controller.
//   - direction and game-state codes
//   - grid / cell / body geometry
//   - key decode, reverse-direction test and next-head arithmetic
// -----------------------------------------------------------------------------
package snake_pkg;

    localparam int GRID_W   = 8;
    localparam int CELL_W   = 6;
    localparam int BODY_LEN = 4;
    localparam int COORD_W  = $clog2(GRID_W);

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_RUN   = 2'd1,
        GS_PAUSE = 2'd2,
        GS_DIE   = 2'd3
    } game_state_t;

    function automatic logic key_onehot(input logic [3:0] k);
        return (k == 4'b0001) || (k == 4'b0010) || (k == 4'b0100) || (k == 4'b1000);
    endfunction

    // Only meaningful when key_onehot(k) is true.
    function automatic dir_t key_to_dir(input logic [3:0] k);
        dir_t d;
        case (k)
            4'b0001: d = DIR_UP;
            4'b0010: d = DIR_DOWN;
            4'b0100: d = DIR_LEFT;
            default: d = DIR_RIGHT;
        endcase
        return d;
    endfunction

    // Opposite headings share the axis bit [1] and differ in bit [0].
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    // Row and column each wrap independently on the torus.
    function automatic logic [CELL_W-1:0] next_head(input logic [CELL_W-1:0] h,
                                                    input dir_t d);
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
        logic [CELL_W-1:0]  nh;
        row = h[CELL_W-1:COORD_W];
        col = h[COORD_W-1:0];
        case (d)
            DIR_UP:   nh = {row - 3'd1, col};
            DIR_DOWN: nh = {row + 3'd1, col};
            DIR_LEFT: nh = {row, col - 3'd1};
            default:  nh = {row, col + 3'd1};
        endcase
        return nh;
    endfunction

endpackage

// File: rtl/snake_game_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// snake_tick_gen
// Movement tick counter. Counts 0..TICK_CYCLES-1 while enabled and raises
// tick combinationally on the last count; wraps to 0 on the next enabled edge.
// Ports:
//   sys_clk   in  clock
//   sys_rst_n in  synchronous active-low reset
//   en        in  advance the counter this cycle
//   clr       in  force the counter to 0 (wins over en)
//   tick      out counter is at its terminal value
// -----------------------------------------------------------------------------
module snake_tick_gen #(
    parameter int TICK_CYCLES = 10_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Raw terminal count; the controller decides in which states it counts.
    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// -----------------------------------------------------------------------------
// snake_game_ctrl
// Game-level sequencer for the 8x8 snake datapath: movement tick, direction
// key filter, self-collision check and the IDLE/RUN/PAUSE/DIE flow.
// Ports:
//   sys_clk    in   clock
//   sys_rst_n  in   synchronous active-low reset
//   key_dir    in   one-hot direction pulse (b0 UP, b1 DOWN, b2 LEFT, b3 RIGHT)
//   key_pause  in   pause toggle pulse
//   snake_body in   4 cells x 6 bit, head [23:18], tail [5:0]
//   step       out  one-cycle pulse, datapath advances one cell
//   dir        out  committed heading
//   restart    out  one-cycle pulse, datapath reloads its reset body
//   game_state out  IDLE/RUN/PAUSE/DIE
//   score      out  successful steps since last restart, saturating
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for first direction key, tick counter held at 0
// RUN   | ticking; each tick steps or detects a collision
// PAUSE | tick counter frozen, keys still update pending heading
// DIE   | counting DIE_TICKS ticks, then restart pulse and back to IDLE
// -----------------------------------------------------------------------------
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_CYCLES = 10_000_000,
    parameter int DIE_TICKS   = 4
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic [3:0]                   key_dir,
    input  logic                         key_pause,
    input  logic [BODY_LEN*CELL_W-1:0]   snake_body,
    output logic                         step,
    output logic [1:0]                   dir,
    output logic                         restart,
    output logic [1:0]                   game_state,
    output logic [7:0]                   score
);

    localparam int DIE_W = (DIE_TICKS > 1) ? $clog2(DIE_TICKS) : 1;
    localparam logic [DIE_W-1:0] DIE_LAST = DIE_W'(DIE_TICKS - 1);

    localparam int HEAD_LSB = (BODY_LEN - 1) * CELL_W;
    localparam int C1_LSB   = (BODY_LEN - 2) * CELL_W;
    localparam int C2_LSB   = (BODY_LEN - 3) * CELL_W;

    game_state_t       state_q, state_d;
    dir_t              dir_q, dir_d;
    dir_t              pend_q, pend_d;
    logic [7:0]        score_q, score_d;
    logic [DIE_W-1:0]  die_q, die_d;
    logic              step_q, step_d;
    logic              restart_q, restart_d;

    logic              tick;
    logic              cnt_en;
    logic              cnt_clr;
    logic              key_ok;
    dir_t              key_code;
    logic [CELL_W-1:0] head_nxt;
    logic              collide;
    logic              unused_tail;

    snake_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (cnt_en),
        .clr       (cnt_clr),
        .tick      (tick)
    );

    assign key_ok   = key_onehot(key_dir) && (state_q != GS_DIE);
    assign key_code = key_to_dir(key_dir);

    // The tail cell vacates on the same step, so only the two middle cells
    // can be hit.
    assign head_nxt = next_head(snake_body[HEAD_LSB +: CELL_W], pend_q);
    assign collide  = (head_nxt == snake_body[C1_LSB +: CELL_W]) ||
                      (head_nxt == snake_body[C2_LSB +: CELL_W]);
    assign unused_tail = ^snake_body[CELL_W-1:0];

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        pend_d    = pend_q;
        score_d   = score_q;
        die_d     = die_q;
        step_d    = 1'b0;
        restart_d = 1'b0;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;

        // Reverse test against the committed heading so that two quick keys
        // between ticks can never fold the snake back on itself.
        if (key_ok && !is_reverse(key_code, dir_q)) begin
            pend_d = key_code;
        end

        case (state_q)
            GS_IDLE: begin
                cnt_clr = 1'b1;
                if (key_ok) begin
                    state_d = GS_RUN;
                end
            end

            GS_RUN: begin
                // A pause freezes the counter, except that a tick in the same
                // cycle is consumed and the counter wraps.
                cnt_en = !key_pause || tick;
                if (tick) begin
                    if (collide) begin
                        state_d = GS_DIE;
                        die_d   = '0;
                    end else begin
                        step_d = 1'b1;
                        dir_d  = pend_q;
                        if (score_q != 8'hFF) begin
                            score_d = score_q + 8'd1;
                        end
                    end
                end
                if (key_pause && (state_d == GS_RUN)) begin
                    state_d = GS_PAUSE;
                end
            end

            GS_PAUSE: begin
                if (key_pause) begin
                    state_d = GS_RUN;
                end
            end

            GS_DIE: begin
                cnt_en = 1'b1;
                if (tick) begin
                    if (die_q == DIE_LAST) begin
                        restart_d = 1'b1;
                        state_d   = GS_IDLE;
                        score_d   = 8'd0;
                        dir_d     = DIR_LEFT;
                        pend_d    = DIR_LEFT;
                        die_d     = '0;
                        cnt_clr   = 1'b1;
                    end else begin
                        die_d = die_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = GS_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= GS_IDLE;
            dir_q     <= DIR_LEFT;
            pend_q    <= DIR_LEFT;
            score_q   <= 8'd0;
            die_q     <= '0;
            step_q    <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            score_q   <= score_d;
            die_q     <= die_d;
            step_q    <= step_d;
            restart_q <= restart_d;
        end
    end

    assign step       = step_q;
    assign dir        = dir_q;
    assign restart    = restart_q;
    assign game_state = state_q;
    assign score      = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
module tb_snake_game_ctrl;

    localparam int TICK  = 4;
    localparam int DIE_T = 3;

    logic        sys_clk    = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic [3:0]  key_dir    = 4'd0;
    logic        key_pause  = 1'b0;
    logic [23:0] snake_body = 24'd0;
    logic        step;
    logic [1:0]  dir;
    logic        restart;
    logic [1:0]  game_state;
    logic [7:0]  score;

    always #5 sys_clk = ~sys_clk;

    snake_game_ctrl #(
        .TICK_CYCLES (TICK),
        .DIE_TICKS   (DIE_T)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_dir    (key_dir),
        .key_pause  (key_pause),
        .snake_body (snake_body),
        .step       (step),
        .dir        (dir),
        .restart    (restart),
        .game_state (game_state),
        .score      (score)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next head on the 8x8 torus: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
    function automatic int nhead(input int h, input int d);
        int r;
        int c;
        r = h / 8;
        c = h % 8;
        case (d)
            0:       r = (r + 7) % 8;
            1:       r = (r + 1) % 8;
            2:       c = (c + 7) % 8;
            default: c = (c + 1) % 8;
        endcase
        return r * 8 + c;
    endfunction

    function automatic logic [23:0] mk_body(input int a, input int b, input int c, input int d);
        return {6'(a), 6'(b), 6'(c), 6'(d)};
    endfunction

    // Reference model: the game rules at cycle granularity.
    // States 0 IDLE, 1 RUN, 2 PAUSE, 3 DIE.
    int m_state = 0, m_dir = 2, m_pend = 2, m_score = 0;
    int m_cnt = 0, m_die = 0, m_step = 0, m_restart = 0;

    always @(posedge sys_clk) begin : model
        int  s, kd, nh, new_pend;
        bit  tk;
        if (!sys_rst_n) begin
            m_state = 0; m_dir = 2; m_pend = 2; m_score = 0;
            m_cnt = 0; m_die = 0; m_step = 0; m_restart = 0;
        end else begin
            s  = m_state;
            tk = (s == 1 || s == 3) && (m_cnt == TICK - 1);
            kd = -1;
            if ($countones(key_dir) == 1)
                for (int i = 0; i < 4; i++) if (key_dir[i]) kd = i;
            new_pend = m_pend;
            if (kd >= 0 && s != 3 && !((kd / 2) == (m_dir / 2) && kd != m_dir))
                new_pend = kd;
            m_step = 0;
            m_restart = 0;
            case (s)
                0: begin
                    m_cnt = 0;
                    if (kd >= 0) m_state = 1;
                end
                1: begin
                    if (tk) begin
                        m_cnt = 0;
                        nh = nhead(int'(snake_body[23:18]), m_pend);
                        if (nh == int'(snake_body[17:12]) || nh == int'(snake_body[11:6])) begin
                            m_state = 3;
                            m_die = 0;
                        end else begin
                            m_step = 1;
                            m_dir = m_pend;
                            if (m_score < 255) m_score++;
                        end
                    end else if (!key_pause) begin
                        m_cnt++;
                    end
                    if (key_pause && m_state == 1) m_state = 2;
                end
                2: begin
                    if (key_pause) m_state = 1;
                end
                default: begin
                    if (tk) begin
                        m_cnt = 0;
                        m_die++;
                        if (m_die == DIE_T) begin
                            m_restart = 1; m_state = 0; m_score = 0;
                            m_dir = 2; new_pend = 2; m_die = 0;
                        end
                    end else begin
                        m_cnt++;
                    end
                end
            endcase
            m_pend = new_pend;
        end
    end

    always @(negedge sys_clk) begin
        if (cmp_on) begin
            check("step",       int'(step),       m_step);
            check("dir",        int'(dir),        m_dir);
            check("restart",    int'(restart),    m_restart);
            check("game_state", int'(game_state), m_state);
            check("score",      int'(score),      m_score);
        end
    end

    task automatic pulse_key(input logic [3:0] k);
        key_dir = k;
        @(negedge sys_clk);
        key_dir = 4'd0;
    endtask

    task automatic pulse_pause();
        key_pause = 1'b1;
        @(negedge sys_clk);
        key_pause = 1'b0;
    endtask

    function automatic bit cond_met(input int which);
        case (which)
            0:       return step === 1'b1;
            1:       return restart === 1'b1;
            default: return game_state === 2'd3;
        endcase
    endfunction

    // Counts negedges until the condition holds; returns budget on timeout.
    task automatic wait_for(input int which, input int budget, output int n);
        n = 0;
        while (n < budget && !cond_met(which)) begin
            @(negedge sys_clk);
            n++;
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int cnt_steps;
        int h;
        sys_rst_n  = 1'b0;
        snake_body = mk_body(44, 45, 46, 47);
        repeat (3) @(negedge sys_clk);
        cmp_on = 1'b1;
        check("reset_state", int'(game_state), 0);
        check("reset_dir",   int'(dir),        2);
        check("reset_score", int'(score),      0);
        sys_rst_n = 1'b1;

        check("model_left_row_wrap", nhead(40, 2), 47);
        check("model_up_wrap",       nhead(3, 0),  59);
        check("model_down_hit",      nhead(27, 1), 35);
        check("model_left_tail",     nhead(27, 2), 26);

        @(negedge sys_clk);

        // First key and first step latency.
        pulse_key(4'b0100);
        check("run_after_key", int'(game_state), 1);
        wait_for(0, 20, n);
        check("first_step_latency", n + 1, 5);
        check("first_step_dir",   int'(dir),   2);
        check("first_step_score", int'(score), 1);

        // Reverse key ignored; two keys in one tick period cannot reverse.
        pulse_key(4'b1000);
        wait_for(0, 20, n);
        check("reverse_step_gap",    n,         3);
        check("reverse_ignored_dir", int'(dir), 2);
        pulse_key(4'b0001);
        pulse_key(4'b1000);
        wait_for(0, 20, n);
        check("two_keys_dir",   int'(dir),   0);
        check("two_keys_score", int'(score), 3);

        // Row-local wrap: head 40 LEFT goes to 47, not 39.
        snake_body = mk_body(40, 39, 41, 42);
        pulse_key(4'b0100);
        wait_for(0, 20, n);
        check("row_wrap_step", int'(step), 1);
        check("row_wrap_dir",  int'(dir),  2);

        // Head 3 UP wraps to 59; a wrong direction would hit 11.
        snake_body = mk_body(3, 11, 4, 5);
        pulse_key(4'b0001);
        wait_for(0, 20, n);
        check("up_wrap_step", int'(step), 1);
        check("up_wrap_dir",  int'(dir),  0);

        // Tail excluded from the collision check.
        snake_body = mk_body(27, 35, 34, 26);
        pulse_key(4'b0100);
        wait_for(0, 20, n);
        check("tail_excluded_step", int'(step),  1);
        check("tail_excluded_dir",  int'(dir),   2);
        check("tail_score",         int'(score), 6);

        // Self-collision, DIE, timed restart.
        pulse_key(4'b0010);
        wait_for(2, 20, n);
        check("collide_state",   int'(game_state), 3);
        check("collide_no_step", int'(step),       0);
        check("die_score_held",  int'(score),      6);
        wait_for(1, 60, n);
        check("die_duration",  n,                TICK * DIE_T);
        check("restart_pulse", int'(restart),    1);
        check("restart_idle",  int'(game_state), 0);
        check("restart_score", int'(score),      0);
        check("restart_dir",   int'(dir),        2);
        @(negedge sys_clk);

        // Rejected reverse still starts the game; pending was reset to LEFT.
        snake_body = mk_body(44, 45, 46, 47);
        pulse_key(4'b1000);
        check("reverse_key_starts", int'(game_state), 1);
        @(negedge sys_clk);
        @(negedge sys_clk);
        pulse_pause();
        check("paused", int'(game_state), 2);
        cnt_steps = 0;
        repeat (100) begin
            @(negedge sys_clk);
            if (step === 1'b1) cnt_steps++;
        end
        check("pause_no_step", cnt_steps,        0);
        check("still_paused",  int'(game_state), 2);
        pulse_pause();
        wait_for(0, 20, n);
        check("resume_gap",   n,           2);
        check("resume_dir",   int'(dir),   2);
        check("resume_score", int'(score), 1);

        // Reset during DIE.
        snake_body = mk_body(27, 35, 34, 26);
        pulse_key(4'b0010);
        wait_for(2, 20, n);
        check("die_before_reset", int'(game_state), 3);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check("rst_die_state",   int'(game_state), 0);
        check("rst_die_dir",     int'(dir),        2);
        check("rst_die_score",   int'(score),      0);
        check("rst_die_restart", int'(restart),    0);
        check("rst_die_step",    int'(step),       0);
        @(negedge sys_clk);

        // Long safe run to reach score saturation, random keys.
        snake_body = mk_body(0, 9, 18, 27);
        pulse_key(4'b0100);
        repeat (1100) begin
            key_dir = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
            @(negedge sys_clk);
        end
        key_dir = 4'd0;
        check("score_saturated", int'(score), 255);

        // Fully random phase with collision-biased bodies.
        repeat (3000) begin
            case ($urandom_range(0, 7))
                4, 5:    key_dir = 4'(1 << $urandom_range(0, 3));
                6:       key_dir = 4'($urandom_range(0, 15));
                default: key_dir = 4'd0;
            endcase
            key_pause = ($urandom_range(0, 29) == 0);
            h = $urandom_range(0, 63);
            snake_body = mk_body(h,
                ($urandom_range(0, 2) == 0) ? nhead(h, $urandom_range(0, 3)) : $urandom_range(0, 63),
                ($urandom_range(0, 2) == 0) ? nhead(h, $urandom_range(0, 3)) : $urandom_range(0, 63),
                ($urandom_range(0, 1) == 0) ? nhead(h, $urandom_range(0, 3)) : $urandom_range(0, 63));
            sys_rst_n = ($urandom_range(0, 599) != 0);
            @(negedge sys_clk);
        end
        key_dir   = 4'd0;
        key_pause = 1'b0;
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
